// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sequencer sharing one combinational ALU between two requesters
//   clk, rst_n (async active-low)
//   req{0,1}_valid/ready/ctrl/a/b : operation request channels
//   alu_control, alu_a, alu_b     : registered operands to the ALU; alu_result comes back combinationally
//   rsp_valid/ready/id/data/err   : tagged response channel with backpressure
//   Optional ALU_ARB_ILLEGAL_CHECK_EN: flag illegal control codes and force their data to all ones
module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic              req1_valid,
  output logic              req0_ready,
  output logic              req1_ready,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic [CTRL_W-1:0] req1_ctrl,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic [CTRL_W-1:0] alu_control,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state;
  logic last;
  logic gnt1;
  // port 1 wins when alone, or on a tie when port 0 took the previous grant
  always_comb gnt1 = req1_valid && (!req0_valid || !last);
  assign req0_ready = (state == IDLE) && req0_valid && !gnt1;
  assign req1_ready = (state == IDLE) && gnt1;
`ifdef ALU_ARB_ILLEGAL_CHECK_EN
  // bit n set when control code n is legal: 0-3,6-9,11,13,14,16-20,38
  localparam logic [63:0] LEGAL_MASK = 64'h0000_0040_001F_6BCF;
  logic legal;
  always_comb legal = LEGAL_MASK[alu_control];
`else
  assign rsp_err = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last        <= 1'b1;
      alu_control <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= 1'b0;
      rsp_data    <= '0;
`ifdef ALU_ARB_ILLEGAL_CHECK_EN
      rsp_err     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (req0_valid || req1_valid) begin
          alu_control <= gnt1 ? req1_ctrl : req0_ctrl;
          alu_a       <= gnt1 ? req1_a : req0_a;
          alu_b       <= gnt1 ? req1_b : req0_b;
          rsp_id      <= gnt1;
          last        <= gnt1;
          state       <= EXEC;
        end
        EXEC: begin
`ifdef ALU_ARB_ILLEGAL_CHECK_EN
          rsp_data  <= legal ? alu_result : '1;
          rsp_err   <= !legal;
`else
          rsp_data  <= alu_result;
`endif
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: table vectors, corner-case sequences and a random run against a transaction model
module tb_alu_share_arbiter;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        req0_valid = 0, req1_valid = 0;
  logic        req0_ready, req1_ready;
  logic [5:0]  req0_ctrl = 0, req1_ctrl = 0;
  logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic [5:0]  alu_control;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        rsp_valid, rsp_ready = 1, rsp_id, rsp_err;
  logic [31:0] rsp_data;

  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.DATA_W(32), .CTRL_W(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_ctrl(req0_ctrl), .req1_ctrl(req1_ctrl),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .alu_control(alu_control), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  function automatic logic [31:0] alu_fn(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      6'd0:  return a & b;
      6'd1:  return a | b;
      6'd2:  return a + b;
      6'd3:  return a ^ b;
      6'd6:  return a - b;
      6'd7:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'd8:  return a << b[4:0];
      6'd9:  return a >> b[4:0];
      6'd11: return $signed(a) >>> b[4:0];
      6'd13: return ~(a | b);
      6'd14: return a * b;
      6'd20: return (a < b) ? 32'd1 : 32'd0;
      default: return a ^ b ^ 32'h5A5A_5A5A;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_control, alu_a, alu_b);

  // expected {err, data} for an operation as seen on the response channel
  function automatic logic [32:0] expect_rsp(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b);
`ifdef ALU_ARB_ILLEGAL_CHECK_EN
    if (!(c inside {6'd0, 6'd1, 6'd2, 6'd3, 6'd6, 6'd7, 6'd8, 6'd9, 6'd11, 6'd13, 6'd14,
                    6'd16, 6'd17, 6'd18, 6'd19, 6'd20, 6'd38}))
      return {1'b1, 32'hFFFF_FFFF};
`endif
    return {1'b0, alu_fn(c, a, b)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_rsp(input string name);
    int w = 0;
    while (!rsp_valid && w < 12) begin
      @(negedge clk); #1;
      w++;
    end
    check({name, "_timeout"}, rsp_valid, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic drain();
    req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    repeat (4) @(negedge clk);
  endtask

  typedef struct {
    string       name;
    logic        port;
    logic [5:0]  c;
    logic [31:0] a, b;
    logic [31:0] d;
    logic        e;
  } vec_t;

  vec_t vecs[7];
  logic [31:0] hold_d;
  logic        hold_id;
  int          cyc;

  initial begin
    vecs[0] = '{"add",   1'b0, 6'd2,  32'd5,        32'd7, 32'd12, 1'b0};
    vecs[1] = '{"slt",   1'b0, 6'd7,  32'hFFFF_FFFF, 32'd1, 32'd1,  1'b0};
    vecs[2] = '{"sltu",  1'b1, 6'd20, 32'hFFFF_FFFF, 32'd1, 32'd0,  1'b0};
    vecs[3] = '{"sub",   1'b1, 6'd6,  32'd10,       32'd3, 32'd7,  1'b0};
    vecs[4] = '{"and",   1'b0, 6'd0,  32'hF0,       32'h3C, 32'h30, 1'b0};
    vecs[5] = '{"sll",   1'b1, 6'd8,  32'h1,        32'd31, 32'h8000_0000, 1'b0};
`ifdef ALU_ARB_ILLEGAL_CHECK_EN
    vecs[6] = '{"illegal", 1'b0, 6'd5, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b1};
`else
    vecs[6] = '{"illegal", 1'b0, 6'd5, 32'd0, 32'd0, 32'h5A5A_5A5A, 1'b0};
`endif

    // reset values while held in reset
    @(negedge clk); #1;
    check("rst_valid", rsp_valid, 0);
    check("rst_id", rsp_id, 0);
    check("rst_data", rsp_data, 0);
    check("rst_err", rsp_err, 0);
    check("rst_ctrl", alu_control, 0);
    check("rst_a", alu_a, 0);
    check("rst_b", alu_b, 0);
    @(negedge clk);
    rst_n = 1;

    // latency sequence: grant at edge 0, response visible from edge 1, handshake at edge 2
    req0_valid = 1; req0_ctrl = 2; req0_a = 5; req0_b = 7; rsp_ready = 1;
    #1;
    check("lat_rdy0", req0_ready, 1);
    check("lat_rdy1", req1_ready, 0);
    @(negedge clk); #1;
    check("lat_exec_rdy0", req0_ready, 0);
    check("lat_exec_valid", rsp_valid, 0);
    check("lat_alu_ctrl", alu_control, 2);
    check("lat_alu_a", alu_a, 5);
    check("lat_alu_b", alu_b, 7);
    req0_valid = 0;
    @(negedge clk); #1;
    check("lat_valid", rsp_valid, 1);
    check("lat_data", rsp_data, 12);
    check("lat_id", rsp_id, 0);
    check("lat_err", rsp_err, 0);
    @(negedge clk); #1;
    check("lat_done", rsp_valid, 0);
    req0_valid = 1;
    #1;
    check("lat_idle_rdy", req0_ready, 1);
    req0_valid = 0;
    drain();

    // table vectors, one operation at a time
    foreach (vecs[i]) begin
      @(negedge clk);
      if (vecs[i].port) begin
        req1_valid = 1; req1_ctrl = vecs[i].c; req1_a = vecs[i].a; req1_b = vecs[i].b;
      end else begin
        req0_valid = 1; req0_ctrl = vecs[i].c; req0_a = vecs[i].a; req0_b = vecs[i].b;
      end
      #1;
      check({vecs[i].name, "_rdy"}, vecs[i].port ? req1_ready : req0_ready, 1);
      @(negedge clk);
      req0_valid = 0; req1_valid = 0;
      #1;
      wait_rsp(vecs[i].name);
      check({vecs[i].name, "_id"}, rsp_id, vecs[i].port);
      check({vecs[i].name, "_data"}, rsp_data, vecs[i].d);
      check({vecs[i].name, "_err"}, rsp_err, vecs[i].e);
      @(negedge clk);
    end
    drain();

    // both requesters always valid: strict alternation starting with port 0, one response per 3 cycles
    do_reset();
    req0_valid = 1; req0_ctrl = 6; req0_a = 10; req0_b = 3;
    req1_valid = 1; req1_ctrl = 0; req1_a = 32'hF0; req1_b = 32'h3C;
    #1;
    wait_rsp("alt_first");
    for (int k = 0; k < 6; k++) begin
      check("alt_id", rsp_id, k % 2);
      check("alt_data", rsp_data, (k % 2) ? 32'h30 : 32'd7);
      cyc = 0;
      @(negedge clk); #1;
      cyc++;
      while (!rsp_valid && cyc < 12) begin
        @(negedge clk); #1;
        cyc++;
      end
      check("alt_spacing", cyc, 3);
    end
    drain();

    // backpressure: response held stable, no grants while stalled
    @(negedge clk);
    req0_valid = 1; req0_ctrl = 3; req0_a = 32'h1234_5678; req0_b = 32'h0F0F_0F0F; rsp_ready = 0;
    @(negedge clk);
    req0_valid = 0;
    #1;
    wait_rsp("bp");
    hold_d = rsp_data; hold_id = rsp_id;
    check("bp_data", hold_d, 32'h1234_5678 ^ 32'h0F0F_0F0F);
    req0_valid = 1; req1_valid = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      check("bp_valid", rsp_valid, 1);
      check("bp_hold_data", rsp_data, hold_d);
      check("bp_hold_id", rsp_id, hold_id);
      check("bp_rdy0", req0_ready, 0);
      check("bp_rdy1", req1_ready, 0);
    end
    rsp_ready = 1;
    @(negedge clk); #1;
    check("bp_done", rsp_valid, 0);
    drain();

    // reset during EXEC after a port-0 grant: next tie still goes to port 0
    @(negedge clk);
    req0_valid = 1; req0_ctrl = 2; req0_a = 1; req0_b = 2;
    @(negedge clk);
    req0_valid = 0;
    rst_n = 0;
    #1;
    check("rexec_ctrl", alu_control, 0);
    check("rexec_a", alu_a, 0);
    check("rexec_b", alu_b, 0);
    check("rexec_valid", rsp_valid, 0);
    @(negedge clk);
    rst_n = 1;
    req0_valid = 1; req1_valid = 1;
    #1;
    check("rexec_tie0", req0_ready, 1);
    check("rexec_tie1", req1_ready, 0);
    req0_valid = 0; req1_valid = 0;
    drain();

    // reset during RESP: pending response lost
    @(negedge clk);
    req0_valid = 1; req0_ctrl = 1; req0_a = 32'hA0; req0_b = 32'h0B; rsp_ready = 0;
    @(negedge clk);
    req0_valid = 0;
    #1;
    wait_rsp("rresp");
    check("rresp_pre_data", rsp_data, 32'hAB);
    rst_n = 0;
    #1;
    check("rresp_valid", rsp_valid, 0);
    check("rresp_data", rsp_data, 0);
    check("rresp_id", rsp_id, 0);
    check("rresp_a", alu_a, 0);
    @(negedge clk);
    rst_n = 1; rsp_ready = 1;
    req0_valid = 1; req1_valid = 1;
    #1;
    check("rresp_tie0", req0_ready, 1);
    check("rresp_tie1", req1_ready, 0);
    req0_valid = 0; req1_valid = 0;

    // randomized run against a transaction-level model
    do_reset();
    begin
      int          ph = 0;
      logic        mlast = 1;
      logic        mid = 0, me = 0, g0, g1;
      logic [5:0]  mc = 0;
      logic [31:0] ma = 0, mb = 0, md = 0;
      for (int t = 0; t < 800; t++) begin
        @(negedge clk);
        req0_valid = $urandom_range(0, 1) != 0;
        req1_valid = $urandom_range(0, 1) != 0;
        req0_ctrl = 6'($urandom_range(0, 63));
        req1_ctrl = 6'($urandom_range(0, 63));
        req0_a = $urandom; req0_b = $urandom;
        req1_a = $urandom; req1_b = $urandom;
        rsp_ready = $urandom_range(0, 3) != 0;
        #1;
        g1 = req1_valid && (!req0_valid || !mlast);
        g0 = req0_valid && !g1;
        check("rnd_rdy0", req0_ready, ph == 0 && g0);
        check("rnd_rdy1", req1_ready, ph == 0 && g1);
        check("rnd_valid", rsp_valid, ph == 2);
        if (ph == 2) begin
          check("rnd_id", rsp_id, mid);
          check("rnd_data", rsp_data, md);
          check("rnd_err", rsp_err, me);
        end
        if (ph != 0) begin
          check("rnd_alu_ctrl", alu_control, mc);
          check("rnd_alu_a", alu_a, ma);
          check("rnd_alu_b", alu_b, mb);
        end
        @(posedge clk);
        if (ph == 0 && (g0 || g1)) begin
          mid = g1;
          mc = g1 ? req1_ctrl : req0_ctrl;
          ma = g1 ? req1_a : req0_a;
          mb = g1 ? req1_b : req0_b;
          {me, md} = expect_rsp(mc, ma, mb);
          mlast = g1;
          ph = 1;
        end else if (ph == 1) ph = 2;
        else if (ph == 2 && rsp_ready) ph = 0;
      end
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
